// File: rtl/freq_seq_pkg.sv
// Shared definitions for the frequency-step sequencer.
//   CNT_W_DEF / DUR_W_DEF / DEPTH_DEF : default widths and table depth
//   F_CLK_HZ                          : system clock frequency the block runs from
//   seq_state_t                       : sequencer FSM state encoding
package freq_seq_pkg;

  localparam int unsigned CNT_W_DEF = 26;
  localparam int unsigned DUR_W_DEF = 16;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned F_CLK_HZ  = 60_000_000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } seq_state_t;

endpackage

// File: rtl/freq_div_core.sv
// Half-period counter and registered output toggle.
//   clk, rst_n : system clock, async active-low reset
//   en         : count while high; when low the counter and output are held at 0
//   load       : clear count and output (start of a new entry or return to idle)
//   div        : half-period length minus 1, in clk cycles
//   clk_out    : divided clock, registered
//   rise, fall : strobes, high in the cycle whose closing edge toggles clk_out up / down
module freq_div_core #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  output logic             clk_out,
  output logic             rise,
  output logic             fall
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             out_q, out_d;
  logic             tick;

  always_comb begin
    tick    = en && (count_q == div);
    rise    = tick && !out_q;
    fall    = tick && out_q;
    count_d = count_q;
    out_d   = out_q;
    if (load || !en) begin
      count_d = '0;
      out_d   = 1'b0;
    end else if (tick) begin
      count_d = '0;
      out_d   = ~out_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      out_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign clk_out = out_q;

endmodule

// File: rtl/freq_step_sequencer.sv
// Steps the divided output clock through a table of {divisor, duration} entries.
// Each entry runs for a whole number of output periods; handover to the next entry
// (or to idle) only happens on a falling output edge, so no runt pulses appear.
//   clk, rst_n          : 60 MHz system clock, async active-low reset
//   cfg_we/addr/div/dur : table write port (accepted every cycle)
//   seq_last, loop_en   : last entry index and wrap enable, sampled at each entry end
//   start, stop         : single-cycle pulses to start from entry 0 / request clean abort
//   clk_out             : divided output clock
//   busy                : high while running or stopping
//   cur_idx             : index of the running entry
//   step_pulse          : one cycle per entry advance (including wrap)
//   done                : one cycle on natural end of a non-looping sequence
module freq_step_sequencer
  import freq_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DUR_W = DUR_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [AW-1:0]    seq_last,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic             clk_out,
  output logic             busy,
  output logic [AW-1:0]    cur_idx,
  output logic             step_pulse,
  output logic             done
);

  logic [CNT_W-1:0] div_tab [DEPTH];
  logic [DUR_W-1:0] dur_tab [DEPTH];

  seq_state_t       state_q, state_d;
  logic [AW-1:0]    cur_idx_q, cur_idx_d;
  logic [DUR_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] div_r;
  logic [DUR_W-1:0] dur_r;
  logic             step_q, step_d;
  logic             done_q, done_d;

  logic             load, tab_ld, start_ok;
  logic             rise, fall;
  logic             last_per, at_last;

  // Table has no reset; a write to the running entry only shows up on its next load.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      div_tab[cfg_addr] <= cfg_div;
      dur_tab[cfg_addr] <= cfg_dur;
    end
  end

  assign start_ok = start && !stop;
  // dur 0 behaves as dur 1.
  assign last_per = (dur_r == '0) ? (per_cnt_q == '0) : (per_cnt_q == dur_r - DUR_W'(1));
  // DEPTH-1 also counts as last so a seq_last lowered below cur_idx still terminates.
  assign at_last  = (cur_idx_q == seq_last) || (cur_idx_q == AW'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        // A stop landing on the falling edge itself already completes the high phase.
        if (stop) begin
          state_d = (!clk_out || fall) ? IDLE : STOPPING;
        end else if (fall && last_per && at_last && !loop_en) begin
          state_d = IDLE;
        end
      end
      STOPPING: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control; stop takes precedence over an entry end on the same edge.
  always_comb begin
    load      = 1'b0;
    cur_idx_d = cur_idx_q;
    per_cnt_d = per_cnt_q;
    step_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          load      = 1'b1;
          cur_idx_d = '0;
          per_cnt_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          load = (state_d == IDLE);
        end else if (fall) begin
          if (last_per) begin
            load      = 1'b1;
            per_cnt_d = '0;
            if (!at_last) begin
              cur_idx_d = cur_idx_q + AW'(1);
              step_d    = 1'b1;
            end else if (loop_en) begin
              cur_idx_d = '0;
              step_d    = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            per_cnt_d = per_cnt_q + DUR_W'(1);
          end
        end
      end
      STOPPING: begin
        load = fall;
      end
      default: ;
    endcase
  end

  // Only loads that keep the sequencer running fetch a new table entry.
  assign tab_ld = load && (state_d == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_idx_q <= '0;
      per_cnt_q <= '0;
      div_r     <= '0;
      dur_r     <= '0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cur_idx_q <= cur_idx_d;
      per_cnt_q <= per_cnt_d;
      step_q    <= step_d;
      done_q    <= done_d;
      if (tab_ld) begin
        div_r <= div_tab[cur_idx_d];
        dur_r <= dur_tab[cur_idx_d];
      end
    end
  end

  freq_div_core #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != IDLE),
    .load    (load),
    .div     (div_r),
    .clk_out (clk_out),
    .rise    (rise),
    .fall    (fall)
  );

  assign busy       = (state_q != IDLE);
  assign cur_idx    = cur_idx_q;
  assign step_pulse = step_q;
  assign done       = done_q;

  // The divider only produces edges while the sequencer is active.
  a_rise_busy: assert property (@(posedge clk) disable iff (!rst_n) rise |-> busy);

endmodule

// File: tb/tb_freq_step_sequencer.sv
module tb_freq_step_sequencer;

  localparam int unsigned CNT_W = 26;
  localparam int unsigned DUR_W = 16;
  localparam int          DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [DUR_W-1:0] cfg_dur = '0;
  logic [AW-1:0]    seq_last = '0;
  logic             loop_en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             clk_out, busy, step_pulse, done;
  logic [AW-1:0]    cur_idx;

  always #5 clk = ~clk;

  freq_step_sequencer #(
    .CNT_W (CNT_W),
    .DUR_W (DUR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_div    (cfg_div),
    .cfg_dur    (cfg_dur),
    .seq_last   (seq_last),
    .loop_en    (loop_en),
    .start      (start),
    .stop       (stop),
    .clk_out    (clk_out),
    .busy       (busy),
    .cur_idx    (cur_idx),
    .step_pulse (step_pulse),
    .done       (done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position t (edges since the entry was loaded) decides everything.
  // Output is high when (t / (D+1)) is odd; an entry lasts 2*N*(D+1) edges.
  int     m_mode = 0; // 0 idle, 1 run, 2 stopping
  int     m_idx = 0;
  longint m_d = 0, m_n = 1, t = 0;
  bit     m_clk = 0, m_step = 0, m_done = 0;
  longint m_div [DEPTH];
  longint m_dur [DEPTH];

  always @(posedge clk or negedge rst_n) begin : model
    longint per, t1;
    bit     last, fall_now;
    if (!rst_n) begin
      m_mode = 0; m_idx = 0; m_clk = 0; m_step = 0; m_done = 0; t = 0;
    end else begin
      m_step   = 0;
      m_done   = 0;
      per      = 2 * (m_d + 1);
      t1       = t + 1;
      fall_now = (t1 % per) == 0;
      if (m_mode == 0) begin
        if (start && !stop) begin
          m_mode = 1; m_idx = 0; t = 0;
          m_d = m_div[0]; m_n = (m_dur[0] == 0) ? 1 : m_dur[0];
        end
      end else if (m_mode == 2) begin
        t = t1;
        if (fall_now) m_mode = 0;
      end else if (stop) begin
        t = t1;
        m_mode = (!m_clk || fall_now) ? 0 : 2;
      end else if (t1 == m_n * per) begin
        last = (m_idx == int'(seq_last)) || (m_idx == DEPTH - 1);
        t = 0;
        if (!last || loop_en) begin
          m_idx  = last ? 0 : m_idx + 1;
          m_d    = m_div[m_idx];
          m_n    = (m_dur[m_idx] == 0) ? 1 : m_dur[m_idx];
          m_step = 1;
        end else begin
          m_mode = 0;
          m_done = 1;
        end
      end else begin
        t = t1;
      end
      m_clk = (m_mode != 0) && (((t / (m_d + 1)) % 2) == 1);
      if (cfg_we) begin
        m_div[cfg_addr] = cfg_div;
        m_dur[cfg_addr] = cfg_dur;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("clk_out", clk_out, m_clk);
      check("busy", busy, m_mode != 0);
      check("cur_idx", cur_idx, m_idx);
      check("step_pulse", step_pulse, m_step);
      check("done", done, m_done);
    end
  end

  logic rc_clk [200];
  logic rc_busy [200];
  logic rc_step [200];
  logic rc_done [200];
  int   rc_idx [200];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d, input int n);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_div = CNT_W'(d); cfg_dur = DUR_W'(n);
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Record n cycles after start; optional rewrite of entry 0 at cycle wk, stop pulse at sk.
  task automatic rec(input int n, input int wk, input int wdiv, input int sk);
    for (int k = 0; k < n; k++) begin
      rc_clk[k] = clk_out; rc_busy[k] = busy; rc_step[k] = step_pulse;
      rc_done[k] = done;   rc_idx[k] = int'(cur_idx);
      cfg_we = (k == wk);
      if (k == wk) begin
        cfg_addr = '0; cfg_div = CNT_W'(wdiv); cfg_dur = '0;
      end
      stop = (k == sk);
      tick;
    end
    cfg_we = 1'b0;
    stop   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      tick;
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int cnt, first, steps;
    int st [$];
    int exp_st [4];
    exp_st = '{18, 22, 40, 44};

    #1 rst_n = 1'b0;
    #1;
    check("rst_clk_out", clk_out, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_idx", cur_idx, 0);
    check("rst_step", step_pulse, 0);
    check("rst_done", done, 0);
    repeat (2) tick;
    #2 rst_n = 1'b1;
    tick;
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));

    // Basic two-entry sequence
    wr(0, 2, 3);
    wr(1, 0, 2);
    seq_last = 3'd1;
    loop_en  = 1'b0;
    go;
    rec(40, -1, 0, -1);
    cnt = 0; first = -1; steps = 0;
    for (int k = 0; k < 40; k++) begin
      if (rc_busy[k]) cnt++;
      if (rc_step[k]) steps++;
      if (rc_done[k] && first < 0) first = k;
    end
    check("basic_busy_cycles", cnt, 22);
    check("basic_done_at", first, 22);
    check("basic_steps", steps, 1);
    check("basic_step_at18", rc_step[18], 1);
    check("basic_idx_at18", rc_idx[18], 1);
    check("basic_clk_k2", rc_clk[2], 0);
    check("basic_clk_k3", rc_clk[3], 1);
    check("basic_clk_k5", rc_clk[5], 1);
    check("basic_clk_k6", rc_clk[6], 0);
    check("basic_clk_k19", rc_clk[19], 1);
    check("basic_clk_k20", rc_clk[20], 0);

    // Loop wrap
    loop_en = 1'b1;
    go;
    rec(60, -1, 0, -1);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (rc_step[k]) st.push_back(k);
      if (rc_done[k]) cnt++;
    end
    check("loop_steps", st.size(), 4);
    for (int i = 0; i < 4 && i < st.size(); i++) check("loop_step_time", st[i], exp_st[i]);
    check("loop_no_done", cnt, 0);
    check("loop_idx_k20", rc_idx[20], 1);
    check("loop_idx_k30", rc_idx[30], 0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    wait_idle(40);
    loop_en = 1'b0;

    // Stop while high
    wr(0, 9, 100);
    seq_last = 3'd0;
    go;
    rec(30, -1, 0, 12);
    cnt = 0; steps = 0;
    for (int k = 0; k < 30; k++) begin
      if (rc_clk[k]) cnt++;
      if (rc_done[k]) steps++;
    end
    check("stophi_clk_at_stop", rc_clk[12], 1);
    check("stophi_high_cycles", cnt, 10);
    check("stophi_busy_k19", rc_busy[19], 1);
    check("stophi_busy_k20", rc_busy[20], 0);
    check("stophi_no_done", steps, 0);

    // Stop while low
    go;
    rec(10, -1, 0, 3);
    check("stoplo_busy_k3", rc_busy[3], 1);
    check("stoplo_busy_k4", rc_busy[4], 0);
    check("stoplo_clk_k4", rc_clk[4], 0);

    // Dur 0 and live rewrite of the running entry
    wr(0, 1, 0);
    loop_en = 1'b1;
    go;
    rec(20, 1, 4, -1);
    steps = 0;
    for (int k = 0; k < 20; k++) if (rc_step[k]) steps++;
    check("dur0_clk_k1", rc_clk[1], 0);
    check("dur0_clk_k2", rc_clk[2], 1);
    check("dur0_step_k4", rc_step[4], 1);
    check("dur0_clk_k8", rc_clk[8], 0);
    check("dur0_clk_k9", rc_clk[9], 1);
    check("dur0_step_k14", rc_step[14], 1);
    check("dur0_steps", steps, 2);
    loop_en = 1'b0;
    wait_idle(40);

    // Async reset mid high phase
    wr(0, 1, 1);
    wr(1, 9, 100);
    seq_last = 3'd1;
    go;
    repeat (16) tick;
    check("arst_pre_clk", clk_out, 1);
    check("arst_pre_idx", cur_idx, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_clk_out", clk_out, 0);
    check("arst_busy", busy, 0);
    check("arst_cur_idx", cur_idx, 0);
    tick;
    #2 rst_n = 1'b1;
    tick;

    // Randomised traffic against the model
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    for (int c = 0; c < 3000; c++) begin
      start  = ($urandom_range(0, 19) == 0);
      stop   = ($urandom_range(0, 59) == 0);
      cfg_we = ($urandom_range(0, 24) == 0);
      cfg_addr = AW'($urandom_range(0, DEPTH - 1));
      cfg_div  = CNT_W'($urandom_range(0, 4));
      cfg_dur  = DUR_W'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) seq_last = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 39) == 0) loop_en = 1'($urandom_range(0, 1));
      tick;
    end
    start = 1'b0; cfg_we = 1'b0;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    wait_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
